// File: rtl/phase_sequencer_if.sv
// Memory request/acknowledge handshake between the phase sequencer and memory.
// The master raises mem_req (with mem_we for stores); the slave answers with mem_ack.
interface phase_sequencer_if;
    logic mem_req;
    logic mem_we;
    logic mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        output mem_ack
    );
endinterface

// File: rtl/phase_sequencer.sv
// Multi-cycle controller for the SIMPLE datapath: fetch, register read, ALU, memory and
// writeback phases, memory handshake with a stall timeout, HLT stop and a retired counter.
module phase_sequencer #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [15:0]           i_command,
    input  logic                  i_dec_write,
    input  logic                  i_pc_load_req,
    phase_sequencer_if.master     mem,
    output logic [4:0]            o_phase,
    output logic                  o_ir_load,
    output logic                  o_pc_inc,
    output logic                  o_szcv_load,
    output logic                  o_reg_write,
    output logic                  o_pc_load,
    output logic                  o_running,
    output logic                  o_halted,
    output logic                  o_err,
    output logic [CNT_W-1:0]      o_instr_count
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_P1   = 3'd1;
    localparam logic [2:0] S_P2   = 3'd2;
    localparam logic [2:0] S_P3   = 3'd3;
    localparam logic [2:0] S_P4   = 3'd4;
    localparam logic [2:0] S_P5   = 3'd5;
    localparam logic [2:0] S_HALT = 3'd6;
    localparam logic [2:0] S_ERR  = 3'd7;

    localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    logic [2:0]        r_state;
    logic [2:0]        w_state_next;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0]  r_instr_count;

    logic w_is_alu;
    logic w_is_hlt;
    logic w_is_mem_op;
    logic w_is_store;
    logic w_mem_req;
    logic w_ack;
    logic w_timeout;

    assign w_is_alu    = (i_command[15:14] == 2'b11);
    assign w_is_hlt    = w_is_alu && (i_command[7:4] == 4'b1111);
    assign w_is_mem_op = (i_command[15] == 1'b0);
    assign w_is_store  = (i_command[15:14] == 2'b01);

    assign w_mem_req = (r_state == S_P1) || ((r_state == S_P4) && w_is_mem_op);
    // An ack only counts while a request is outstanding.
    assign w_ack     = w_mem_req && mem.mem_ack;
    assign w_timeout = w_mem_req && !mem.mem_ack && (r_wait_cnt == WAIT_LAST);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_HALT: if (i_start) w_state_next = S_P1;
            S_P1: begin
                if (w_ack)          w_state_next = S_P2;
                else if (w_timeout) w_state_next = S_ERR;
            end
            S_P2:    w_state_next = w_is_hlt ? S_HALT : S_P3;
            S_P3:    w_state_next = S_P4;
            S_P4: begin
                if (!w_is_mem_op || w_ack) w_state_next = S_P5;
                else if (w_timeout)        w_state_next = S_ERR;
            end
            S_P5:    w_state_next = S_P1;
            default: w_state_next = S_ERR;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_wait_cnt    <= '0;
            r_instr_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_mem_req && !mem.mem_ack && (w_state_next == r_state))
                r_wait_cnt <= r_wait_cnt + 1'b1;
            else
                r_wait_cnt <= '0;
            if (r_state == S_P5)
                r_instr_count <= r_instr_count + 1'b1;
        end
    end

    for (genvar gi = 0; gi < 5; gi++) begin : g_phase
        assign o_phase[gi] = (r_state == 3'(gi + 1));
    end

    assign mem.mem_req  = w_mem_req;
    assign mem.mem_we   = (r_state == S_P4) && w_is_store;
    assign o_ir_load    = (r_state == S_P1) && mem.mem_ack;
    assign o_pc_inc     = (r_state == S_P1) && mem.mem_ack;
    assign o_szcv_load  = (r_state == S_P3) && w_is_alu;
    assign o_reg_write  = (r_state == S_P5) && i_dec_write;
    assign o_pc_load    = (r_state == S_P5) && i_pc_load_req;
    assign o_running    = (r_state >= S_P1) && (r_state <= S_P5);
    assign o_halted     = (r_state == S_HALT);
    assign o_err        = (r_state == S_ERR);
    assign o_instr_count = r_instr_count;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer with a short stall timeout (TIMEOUT=4).
module tb_phase_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] command;
    logic        dec_write;
    logic        pc_load_req;
    logic [4:0]  phase;
    logic        ir_load, pc_inc, szcv_load, reg_write, pc_load;
    logic        running, halted, err;
    logic [15:0] instr_count;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    phase_sequencer_if bus ();

    phase_sequencer #(.TIMEOUT(4), .CNT_W(16)) dut (
        .i_clock       (clk),
        .i_reset       (rst),
        .i_start       (start),
        .i_command     (command),
        .i_dec_write   (dec_write),
        .i_pc_load_req (pc_load_req),
        .mem           (bus.master),
        .o_phase       (phase),
        .o_ir_load     (ir_load),
        .o_pc_inc      (pc_inc),
        .o_szcv_load   (szcv_load),
        .o_reg_write   (reg_write),
        .o_pc_load     (pc_load),
        .o_running     (running),
        .o_halted      (halted),
        .o_err         (err),
        .o_instr_count (instr_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the edge.
    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    // All strobes/status packed: {phase, ir_load, pc_inc, mem_req, mem_we, szcv, rw, pl, run, halt, err}
    function automatic logic [31:0] all_outs();
        return 32'({phase, ir_load, pc_inc, bus.mem_req, bus.mem_we, szcv_load,
                    reg_write, pc_load, running, halted, err});
    endfunction

    // Runs one non-memory instruction from P1 (ack=1) to the following P1.
    task automatic run_fast(input string tag, input logic [15:0] cmd, input logic dw,
                            input logic plr, input logic exp_szcv, input logic exp_pl);
        command = cmd; dec_write = dw; pc_load_req = plr; bus.mem_ack = 1'b1;
        settle;
        check({tag, " P1 phase"}, 32'(phase), 32'h01);
        check({tag, " P1 ir_load/pc_inc/req"}, 32'({ir_load, pc_inc, bus.mem_req}), 32'b111);
        cyc; settle;
        check({tag, " P2 phase"}, 32'(phase), 32'h02);
        cyc; settle;
        check({tag, " P3 phase"}, 32'(phase), 32'h04);
        check({tag, " P3 szcv_load"}, 32'(szcv_load), 32'(exp_szcv));
        cyc; settle;
        check({tag, " P4 phase"}, 32'(phase), 32'h08);
        check({tag, " P4 req/pc_load/szcv"}, 32'({bus.mem_req, pc_load, szcv_load}), 32'b000);
        cyc; settle;
        check({tag, " P5 phase"}, 32'(phase), 32'h10);
        check({tag, " P5 reg_write"}, 32'(reg_write), 32'(dw));
        check({tag, " P5 pc_load"}, 32'(pc_load), 32'(exp_pl));
        cyc; settle;
        check({tag, " next P1 pc_load"}, 32'({phase, pc_load}), 32'({5'h01, 1'b0}));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; command = 16'h0000; dec_write = 1'b0;
        pc_load_req = 1'b0; bus.mem_ack = 1'b0;
        cyc; cyc;
        rst = 1'b0; settle;
        check("reset outputs", all_outs(), 32'h0);
        check("reset count", 32'(instr_count), 32'h0);

        // Ack while idle (no request) must not disturb anything.
        bus.mem_ack = 1'b1;
        cyc; settle;
        check("idle ack ignored", all_outs(), 32'h0);

        // ADD with ack tied high
        start = 1'b1; command = 16'hC000;
        cyc; start = 1'b0;
        run_fast("ADD", 16'hC000, 1'b1, 1'b0, 1'b1, 1'b0);
        check("ADD count", 32'(instr_count), 32'd1);

        // LD with ack 3 cycles late in P4: 4th request cycle sits on the timeout boundary
        command = 16'h0000; dec_write = 1'b1; bus.mem_ack = 1'b1;
        cyc; cyc; settle;
        check("LD P3 szcv_load", 32'(szcv_load), 32'h0);
        cyc;
        for (int i = 0; i < 4; i++) begin
            bus.mem_ack = (i == 3);
            settle;
            check($sformatf("LD P4 cyc%0d phase/req/we", i),
                  32'({phase, bus.mem_req, bus.mem_we}), 32'({5'h08, 1'b1, 1'b0}));
            cyc;
        end
        settle;
        check("LD P5 phase/rw/err", 32'({phase, reg_write, err}), 32'({5'h10, 1'b1, 1'b0}));
        cyc; settle;
        check("LD count", 32'(instr_count), 32'd2);

        // ST: store request held until ack, no register write
        command = 16'h4000; dec_write = 1'b0; bus.mem_ack = 1'b1;
        cyc; cyc; cyc;
        bus.mem_ack = 1'b0; settle;
        check("ST P4 wait req/we", 32'({phase, bus.mem_req, bus.mem_we}), 32'({5'h08, 2'b11}));
        cyc;
        bus.mem_ack = 1'b1; settle;
        check("ST P4 ack req/we", 32'({phase, bus.mem_req, bus.mem_we}), 32'({5'h08, 2'b11}));
        cyc; settle;
        check("ST P5 phase/rw/we", 32'({phase, reg_write, bus.mem_we}), 32'({5'h10, 2'b00}));
        cyc;

        // Branch taken then not taken
        run_fast("BT", 16'hA000, 1'b0, 1'b1, 1'b0, 1'b1);
        run_fast("BN", 16'hA000, 1'b0, 1'b0, 1'b0, 1'b0);
        check("branch count", 32'(instr_count), 32'd5);

        // HLT stops after P2 without counting
        command = 16'hC0F0; pc_load_req = 1'b0; bus.mem_ack = 1'b1;
        cyc; settle;
        check("HLT P2 phase", 32'(phase), 32'h02);
        cyc; settle;
        check("HLT state", all_outs(), 32'h2);
        check("HLT count", 32'(instr_count), 32'd5);
        cyc; settle;
        check("HLT holds", 32'(halted), 32'h1);
        start = 1'b1;
        cyc; start = 1'b0; bus.mem_ack = 1'b0; settle;
        check("restart P1", 32'({phase, bus.mem_req, halted}), 32'({5'h01, 1'b1, 1'b0}));

        // Timeout in P1: ERR after 4 unanswered request cycles
        for (int i = 0; i < 4; i++) begin
            settle;
            check($sformatf("TO wait%0d req/err", i), 32'({bus.mem_req, err}), 32'b10);
            cyc;
        end
        settle;
        check("TO err state", all_outs(), 32'h1);
        bus.mem_ack = 1'b1; start = 1'b1;
        cyc; settle; start = 1'b0;
        check("err sticky", all_outs(), 32'h1);

        // Reset exits ERR; then reset again in the middle of a P4 store
        rst = 1'b1; cyc; rst = 1'b0; settle;
        check("err reset", all_outs(), 32'h0);
        command = 16'h4000; bus.mem_ack = 1'b1; start = 1'b1;
        cyc; start = 1'b0;
        cyc; cyc; cyc;
        bus.mem_ack = 1'b0; settle;
        check("mid P4 req", 32'({phase, bus.mem_req}), 32'({5'h08, 1'b1}));
        rst = 1'b1; cyc; rst = 1'b0; settle;
        check("mid-P4 reset outputs", all_outs(), 32'h0);
        check("mid-P4 reset count", 32'(instr_count), 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
